// File: rtl/lut_sweep_if.sv
// Handshake and result bus between a sweep requester and the LUT sweep controller.
// The slave modport is the controller side; the master modport is the requester/LUT side.
interface lut_sweep_if;
  logic        start;
  logic        abort;
  logic [3:0]  lut_b;
  logic        lut_s;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] result;
  logic [4:0]  ones_cnt;
  logic [4:0]  miss_cnt;
  logic [4:0]  false_cnt;

  modport slave (
    input  start, abort, lut_s,
    output lut_b, busy, done, pass, result, ones_cnt, miss_cnt, false_cnt
  );

  modport master (
    output start, abort, lut_s,
    input  lut_b, busy, done, pass, result, ones_cnt, miss_cnt, false_cnt
  );
endinterface

// File: rtl/lut_sweep_ctrl.sv
// Sweeps all 16 codes into a 4-input LUT, samples its output after a settle time,
// and scores the captured truth table against an expected mask.
module lut_sweep_ctrl #(
  parameter logic [15:0] EXP_MASK = 16'h0426,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  lut_sweep_if.slave  bus
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CODE_W-1:0] LAST_CODE   = 4'hF;
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [3:0]        settle_q, settle_d;
  logic [CODE_W-1:0] lut_b_q, lut_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       result_q, result_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0]  false_q, false_d;

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    result_d = result_q;
    ones_d   = ones_q;
    miss_d   = miss_q;
    false_d  = false_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = DRIVE;
          idx_d    = '0;
          settle_d = '0;
          pass_d   = 1'b0;
          result_d = '0;
          ones_d   = '0;
          miss_d   = '0;
          false_d  = '0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      SAMPLE: begin
        // An abort here drops the code being sampled; earlier codes stay captured
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          result_d[idx_q] = bus.lut_s;
          ones_d  = ones_q  + CNT_W'(bus.lut_s);
          miss_d  = miss_q  + CNT_W'(EXP_MASK[idx_q] & ~bus.lut_s);
          false_d = false_q + CNT_W'(~EXP_MASK[idx_q] & bus.lut_s);
          if (idx_q == LAST_CODE) begin
            state_d = FINISH;
            pass_d  = (miss_d == '0) && (false_d == '0);
          end else begin
            state_d  = DRIVE;
            idx_d    = idx_q + 4'd1;
            settle_d = '0;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d  = (state_d == FINISH);
    busy_d  = (state_d != IDLE);
    lut_b_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? idx_d : '0;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      lut_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= '0;
      ones_q   <= '0;
      miss_q   <= '0;
      false_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      lut_b_q  <= lut_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      ones_q   <= ones_d;
      miss_q   <= miss_d;
      false_q  <= false_d;
    end
  end

  assign bus.lut_b     = lut_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.result    = result_q;
  assign bus.ones_cnt  = ones_q;
  assign bus.miss_cnt  = miss_q;
  assign bus.false_cnt = false_q;

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Directed bench for lut_sweep_ctrl: LUT model with ideal/stuck modes and a
// scoreboard of expected sweep outcomes popped at each done pulse.
module tb_lut_sweep_ctrl;

  localparam logic [15:0] EXP_MASK = 16'h0426;
  localparam int unsigned SETTLE   = 1;
  localparam int          DONE_CYC = 16 * (SETTLE + 1) + 1;
  localparam int          MODE_IDEAL = 0, MODE_STUCK0 = 1, MODE_STUCK1 = 2;

  typedef struct {
    logic [15:0] result;
    logic [4:0]  ones;
    logic [4:0]  miss;
    logic [4:0]  fls;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          mode = MODE_IDEAL;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] mask_v = EXP_MASK;
  exp_t        sb[$];

  lut_sweep_if bus();

  lut_sweep_ctrl #(.EXP_MASK(EXP_MASK), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // LUT under test
  assign bus.lut_s = (mode == MODE_IDEAL)  ? mask_v[bus.lut_b] :
                     (mode == MODE_STUCK1) ? 1'b1 : 1'b0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int m);
    exp_t e;
    logic s;
    logic [15:0] msk;
    msk = EXP_MASK;
    e.result = '0; e.ones = '0; e.miss = '0; e.fls = '0;
    for (int b = 0; b < 16; b++) begin
      s = (m == MODE_IDEAL) ? msk[b] : (m == MODE_STUCK1);
      e.result[b] = s;
      if (s) e.ones++;
      if (msk[b] && !s) e.miss++;
      if (!msk[b] && s) e.fls++;
    end
    e.pass = (e.miss == 0) && (e.fls == 0);
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),      32'd0);
    chk({tag, "_done"},   32'(bus.done),      32'd0);
    chk({tag, "_pass"},   32'(bus.pass),      32'd0);
    chk({tag, "_lut_b"},  32'(bus.lut_b),     32'd0);
    chk({tag, "_result"}, 32'(bus.result),    32'd0);
    chk({tag, "_ones"},   32'(bus.ones_cnt),  32'd0);
    chk({tag, "_miss"},   32'(bus.miss_cnt),  32'd0);
    chk({tag, "_false"},  32'(bus.false_cnt), 32'd0);
  endtask

  // Pulse start for one edge; afterwards cycle 1 of the sweep is in progress
  task automatic start_sweep(input int m, input bit push);
    mode = m;
    bus.start = 1'b1;
    if (push) sb.push_back(model(m));
    tick;
    bus.start = 1'b0;
    chk("accept_busy",  32'(bus.busy),  32'd1);
    chk("accept_pass",  32'(bus.pass),  32'd0);
    chk("accept_lut_b", 32'(bus.lut_b), 32'd0);
  endtask

  task automatic advance_to(input int target, inout int cyc);
    while (cyc < target) begin
      tick;
      cyc++;
    end
  endtask

  task automatic finish_sweep(input int c0);
    int   cyc;
    exp_t e;
    cyc = c0;
    while (!bus.done && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("done_cycle", 32'(cyc), 32'(DONE_CYC));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("result", 32'(bus.result),    32'(e.result));
      chk("ones",   32'(bus.ones_cnt),  32'(e.ones));
      chk("miss",   32'(bus.miss_cnt),  32'(e.miss));
      chk("false",  32'(bus.false_cnt), 32'(e.fls));
      chk("pass",   32'(bus.pass),      32'(e.pass));
      tick;
      chk("done_one_cycle", 32'(bus.done),  32'd0);
      chk("idle_busy",      32'(bus.busy),  32'd0);
      chk("idle_lut_b",     32'(bus.lut_b), 32'd0);
      chk("pass_held",      32'(bus.pass),  32'(e.pass));
    end
  endtask

  initial begin
    int cyc;
    int seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Reset state
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Ideal LUT, stuck-at-0, stuck-at-1
    start_sweep(MODE_IDEAL, 1'b1);
    finish_sweep(1);
    start_sweep(MODE_STUCK0, 1'b1);
    finish_sweep(1);
    start_sweep(MODE_STUCK1, 1'b1);
    finish_sweep(1);

    // Second start mid-sweep is ignored
    start_sweep(MODE_IDEAL, 1'b1);
    cyc = 1;
    advance_to(5, cyc);
    chk("lut_b_code2", 32'(bus.lut_b), 32'd2);
    bus.start = 1'b1;
    tick;
    cyc++;
    bus.start = 1'b0;
    finish_sweep(cyc);

    // Abort while sampling code 4
    start_sweep(MODE_IDEAL, 1'b0);
    cyc = 1;
    advance_to(10, cyc);
    bus.abort = 1'b1;
    tick;
    bus.abort = 1'b0;
    chk("abort_busy",   32'(bus.busy),     32'd0);
    chk("abort_lut_b",  32'(bus.lut_b),    32'd0);
    chk("abort_pass",   32'(bus.pass),     32'd0);
    chk("abort_result", 32'(bus.result),   32'h0006);
    chk("abort_ones",   32'(bus.ones_cnt), 32'd2);
    seen = 0;
    repeat (40) begin
      tick;
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Abort wins over start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_busy", 32'(bus.busy), 32'd0);
    tick;
    chk("abort_start_busy2", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-sweep, then a full sweep
    start_sweep(MODE_IDEAL, 1'b0);
    cyc = 1;
    advance_to(20, cyc);
    chk("pre_reset_ones", 32'(bus.ones_cnt), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    seen = 0;
    repeat (3) begin
      tick;
      if (bus.done) seen++;
    end
    chk("reset_no_done", 32'(seen), 32'd0);
    rst_n = 1'b1;
    tick;
    start_sweep(MODE_IDEAL, 1'b1);
    finish_sweep(1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_sweep_ctrl.md
LUT_SWEEP_CTRL -- requirements
Module: lut_sweep_ctrl

Interface
REQ-001 SHALL have parameter EXP_MASK, default 16'h0426, expected LUT output per code (bit n = expected s for b = n).
REQ-002 SHALL have parameter SETTLE, default 1, range 1..15, cycles each code is held before sampling.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a sweep; accepted only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the sweep in progress.
REQ-007 SHALL have port lut_b  output  4  code driven to the LUT input b.
REQ-008 SHALL have port lut_s  input  1  LUT output s, sampled by the controller.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass  output  1  sweep verdict; held until the next accepted start.
REQ-012 SHALL have port result  output  16  captured s per code; bit n = s for b = n.
REQ-013 SHALL have port ones_cnt  output  5  count of codes with s = 1.
REQ-014 SHALL have port miss_cnt  output  5  count of codes with expected 1 and sampled 0.
REQ-015 SHALL have port false_cnt  output  5  count of codes with expected 0 and sampled 1.

Function
REQ-016 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and FINISH.
REQ-017 IDLE: lut_b = 0; start=1 and abort=0 at an edge -> clear result, counters, pass and code index; go to DRIVE.
REQ-018 DRIVE: lut_b = current index; stay SETTLE cycles (4-bit settle counter), then go to SAMPLE.
REQ-019 SAMPLE: lut_b still = index; capture lut_s into result[index].
REQ-020 SAMPLE: ones_cnt += lut_s; miss_cnt += EXP_MASK[index] & ~lut_s; false_cnt += ~EXP_MASK[index] & lut_s.
REQ-021 SAMPLE exit: if index = 15 go to FINISH; else increment index (4-bit, no wrap past 15) and go to DRIVE.
REQ-022 FINISH: assert done for exactly one cycle; pass = (miss_cnt = 0 and false_cnt = 0); lut_b = 0; go to IDLE.
REQ-023 Each code SHALL occupy SETTLE+1 cycles.
REQ-024 done SHALL be high in the 16*(SETTLE+1)+1-th cycle after the start-accept edge (33 for SETTLE=1).
REQ-025 start while busy SHALL be ignored, with no effect on the sweep or outputs.
REQ-026 abort in DRIVE or SAMPLE -> IDLE at the next edge: no done pulse; pass = 0; result and counters keep partial values; lut_b = 0.
REQ-027 abort and start high together in IDLE: abort SHALL win and the sweep SHALL NOT start.
REQ-028 abort in FINISH SHALL be ignored; the sweep completes normally.
REQ-029 Counters SHALL be 5 bits so that 16 is representable without overflow.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from lut_s to any output.

Reset
REQ-031 rst_n = 0 SHALL immediately force the following, regardless of clk:
- state IDLE
- lut_b = 0, busy = 0, done = 0, pass = 0
- result = 16'h0000
- ones_cnt = 0, miss_cnt = 0, false_cnt = 0
REQ-032 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-033 The first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-034 Ideal LUT model (s = EXP_MASK[b]), SETTLE=1, start pulse -> done in cycle 33; pass=1; result=16'h0426; ones_cnt=4; miss_cnt=0; false_cnt=0.
REQ-035 lut_s stuck at 0 -> result=16'h0000; ones_cnt=0; miss_cnt=4; false_cnt=0; pass=0.
REQ-036 lut_s stuck at 1 -> result=16'hFFFF; ones_cnt=16; miss_cnt=0; false_cnt=12; pass=0.
REQ-037 abort at cycle 10 after start -> busy=0 next cycle; lut_b=0; no done within 40 cycles; pass=0.
REQ-038 Second start at cycle 5 of a sweep -> ignored; done still in cycle 33 with unchanged counts.
REQ-039 rst_n low at cycle 20 of a sweep -> all outputs at reset values immediately; a new start then completes a full sweep with correct counts.
